// File: rtl/ram_arb_pkg.sv
// Shared types for the two-requester RAM port arbiter.
// Holds the FSM state encoding, default widths and the requester-id type.
package ram_arb_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick, purely combinational (0 cycles).
// No backpressure of its own; the caller only samples it when ready to accept.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  output req_id_t    winner,
  output logic       any_req
);

  always_comb begin
    any_req = |req;
    // On a tie the requester not granted last wins; otherwise the lone requester.
    if (req == 2'b11) winner = ~last;
    else              winner = req[1];
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one synchronous RAM port between two requesters; read data returns 3 cycles after req.
// Commands are serialised: a req is sampled only in IDLE, so a waiting requester holds req until gnt.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          wr0,
  input  logic          wr1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          ram_en,
  output logic          ram_wr,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  state_t        state;
  req_id_t       last_gnt;
  req_id_t       cur_id;
  logic          cur_wr;
  req_id_t       pick;
  logic          any_req;
  logic          sel_wr;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  rr_arb2 u_arb (
    .req     ({req1, req0}),
    .last    (last_gnt),
    .winner  (pick),
    .any_req (any_req)
  );

  always_comb begin
    sel_wr    = pick ? wr1    : wr0;
    sel_addr  = pick ? addr1  : addr0;
    sel_wdata = pick ? wdata1 : wdata0;
  end

  // ram_addr/ram_wdata double as the command register and hold between commands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cur_id    <= 1'b0;
      cur_wr    <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      ram_en    <= 1'b0;
      ram_wr    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      ram_en  <= 1'b0;
      ram_wr  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            cur_id    <= pick;
            last_gnt  <= pick;
            cur_wr    <= sel_wr;
            ram_en    <= 1'b1;
            ram_wr    <= sel_wr;
            ram_addr  <= sel_addr;
            ram_wdata <= sel_wdata;
            gnt0      <= ~pick;
            gnt1      <= pick;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          state <= cur_wr ? IDLE : RDWAIT;
        end
        RDWAIT: begin
          if (cur_id) begin
            rdata1  <= ram_rdata;
            rvalid1 <= 1'b1;
          end else begin
            rdata0  <= ram_rdata;
            rvalid0 <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with a behavioural 256x8 registered-output RAM on the port.
// Inputs change and outputs are checked on the falling edge, away from the active edge.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, wr0, wr1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata0, rdata1;
  logic       ram_en, ram_wr;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       mem_clr;
  logic [7:0] mem [256];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.AW(8), .DW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (req0),
    .req1      (req1),
    .wr0       (wr0),
    .wr1       (wr1),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
    .gnt0      (gnt0),
    .gnt1      (gnt1),
    .rvalid0   (rvalid0),
    .rvalid1   (rvalid1),
    .rdata0    (rdata0),
    .rdata1    (rdata1),
    .ram_en    (ram_en),
    .ram_wr    (ram_wr),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'h5A;
  endfunction

  // RAM contents are not touched by rst_n, only by mem_clr at start-up.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      ram_rdata <= 8'h00;
    end else if (ram_en) begin
      if (ram_wr) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic set_cmd(input logic who, input logic on, input logic wr,
                         input logic [7:0] a, input logic [7:0] d);
    if (who) begin
      req1 = on; wr1 = wr; addr1 = a; wdata1 = d;
    end else begin
      req0 = on; wr0 = wr; addr0 = a; wdata0 = d;
    end
  endtask

  // Single isolated command; entered and left on a falling edge with the DUT idle.
  task automatic run_cmd(input logic who, input logic wr, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] exp);
    set_cmd(who, 1'b1, wr, a, d);
    @(negedge clk);
    chk("gnt_win",   who ? gnt1 : gnt0, 1);
    chk("gnt_other", who ? gnt0 : gnt1, 0);
    chk("ram_en",    ram_en, 1);
    chk("ram_wr",    ram_wr, wr);
    chk("ram_addr",  ram_addr, a);
    if (wr) chk("ram_wdata", ram_wdata, d);
    set_cmd(who, 1'b0, wr, a, d);
    @(negedge clk);
    chk("en_drop",   ram_en, 0);
    chk("addr_hold", ram_addr, a);
    if (!wr) begin
      chk("rvalid_early", who ? rvalid1 : rvalid0, 0);
      @(negedge clk);
      chk("rvalid_win",   who ? rvalid1 : rvalid0, 1);
      chk("rvalid_other", who ? rvalid0 : rvalid1, 0);
      chk("rdata",        who ? rdata1 : rdata0, exp);
    end
  endtask

  typedef struct {
    logic       who;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int         en_seen;
    int         misc_seen;
    logic       exp_w;
    logic [7:0] ia;
    logic [7:0] a0, a1;
    int         n0, n1;
    int         gcnt, last_g, gap_bad, en_mis, g0_seen;

    vecs[0] = '{1'b0, 1'b1, 8'h10, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
    vecs[3] = '{1'b1, 1'b1, 8'hFF, 8'h3C, 8'h00};
    vecs[4] = '{1'b0, 1'b0, 8'hFF, 8'h00, 8'h3C};
    vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h5A};
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h77, 8'h00};
    vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h77};

    rst_n = 1'b0; mem_clr = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0;

    chk("rst_gnt",    {gnt1, gnt0}, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_en_wr",  {ram_en, ram_wr}, 0);
    chk("rst_addr",   ram_addr, 0);
    chk("rst_wdata",  ram_wdata, 0);
    chk("rst_rdata",  {rdata1, rdata0}, 0);

    en_seen = 0; misc_seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (ram_en) en_seen++;
      if (gnt0 || gnt1 || rvalid0 || rvalid1 || ram_wr) misc_seen++;
    end
    chk("idle_en", en_seen, 0);
    chk("idle_outs", misc_seen, 0);

    for (int i = 0; i < 8; i++)
      run_cmd(vecs[i].who, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

    // Fresh reset so the first tie goes to requester 0.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = 8'h20; a1 = 8'h30; n0 = 1; n1 = 1;
    set_cmd(1'b0, 1'b1, 1'b0, a0, 8'h00);
    set_cmd(1'b1, 1'b1, 1'b0, a1, 8'h00);
    for (int k = 0; k < 5; k++) begin
      exp_w = k[0];
      @(negedge clk);
      chk("alt_gnt0", gnt0, !exp_w);
      chk("alt_gnt1", gnt1, exp_w);
      ia = exp_w ? a1 : a0;
      chk("alt_addr", ram_addr, ia);
      if (exp_w) begin
        if (n1 < 2) begin a1++; n1++; set_cmd(1'b1, 1'b1, 1'b0, a1, 8'h00); end
        else req1 = 1'b0;
      end else begin
        if (n0 < 3) begin a0++; n0++; set_cmd(1'b0, 1'b1, 1'b0, a0, 8'h00); end
        else req0 = 1'b0;
      end
      @(negedge clk);
      @(negedge clk);
      chk("alt_rv_win",   exp_w ? rvalid1 : rvalid0, 1);
      chk("alt_rv_other", exp_w ? rvalid0 : rvalid1, 0);
      chk("alt_rdata",    exp_w ? rdata1 : rdata0, init_val(ia));
    end

    // Last grant becomes 0, then a tie where req1 writes and req0 reads the same address.
    run_cmd(1'b0, 1'b0, 8'h21, 8'h00, init_val(8'h21));
    set_cmd(1'b1, 1'b1, 1'b1, 8'h00, 8'hFF);
    set_cmd(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("tie_gnt", {gnt1, gnt0}, 2'b10);
    chk("tie_wr",  ram_wr, 1);
    req1 = 1'b0;
    @(negedge clk);
    chk("tie_gap", {gnt1, gnt0}, 0);
    @(negedge clk);
    chk("tie_gnt0", gnt0, 1);
    chk("tie_rd",   ram_wr, 0);
    req0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("tie_rv",    rvalid0, 1);
    chk("tie_rdata", rdata0, 8'hFF);

    // Reset lands while the read is in RDWAIT.
    set_cmd(1'b0, 1'b1, 1'b0, 8'h10, 8'h00);
    @(negedge clk);
    chk("abort_gnt", gnt0, 1);
    req0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_rv_a", {rvalid1, rvalid0}, 0);
    @(negedge clk);
    chk("abort_rv_b", {rvalid1, rvalid0}, 0);
    chk("abort_rdata", rdata0, 0);
    run_cmd(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);

    // Back-to-back writes from requester 1 alone.
    gcnt = 0; last_g = 0; gap_bad = 0; en_mis = 0; g0_seen = 0;
    set_cmd(1'b1, 1'b1, 1'b1, 8'h40, 8'hC0);
    for (int c = 0; c < 46; c++) begin
      @(negedge clk);
      if (ram_en !== gnt1) en_mis++;
      if (gnt0) g0_seen++;
      if (gnt1) begin
        if (gcnt > 0 && c - last_g != 2) gap_bad++;
        last_g = c;
        gcnt++;
        if (gcnt < 20) set_cmd(1'b1, 1'b1, 1'b1, 8'(8'h40 + gcnt), 8'(8'hC0 + gcnt));
        else req1 = 1'b0;
      end
    end
    chk("b2b_count", gcnt, 20);
    chk("b2b_gap",   gap_bad, 0);
    chk("b2b_en",    en_mis, 0);
    chk("b2b_gnt0",  g0_seen, 0);
    run_cmd(1'b1, 1'b0, 8'h40, 8'h00, 8'hC0);
    run_cmd(1'b0, 1'b0, 8'h53, 8'h00, 8'hD3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Shares one port of the 256x8 synchronous RAM between two requesters. The arbiter accepts read/write commands through a req/gnt handshake and picks between them round-robin. It drives the RAM enable, write, address and data lines for exactly one cycle per command, and returns read data to the winning requester with a valid pulse. It sits between two client blocks and the RAM port (ena/wr/addr/in/out).

## Interface
Parameters:
- AW, 8, address width (RAM depth 2^AW)
- DW, 8, data width

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- req0 / req1  in  1  request from requester 0 / 1
- wr0 / wr1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  AW  command address; stable while req high
- wdata0 / wdata1  in  DW  write data; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse: command accepted and issued this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: read data valid
- rdata0 / rdata1  out  DW  read data; holds its value until the next rvalid on the same requester
- ram_en  out  1  to RAM enable
- ram_wr  out  1  to RAM write
- ram_addr  out  AW  to RAM address
- ram_wdata  out  DW  to RAM write data
- ram_rdata  in  DW  from RAM registered output; valid one cycle after a read issue

## Operation
- States:
  - IDLE: sample req0/req1. If either is high, select the winner, latch wr/addr/wdata into the command register and the winner id, then go to ISSUE. If neither is high, stay in IDLE.
  - ISSUE: drive ram_en=1, ram_wr=latched wr, ram_addr, ram_wdata, and gnt[winner]=1. Go to IDLE if the command is a write, RDWAIT if it is a read.
  - RDWAIT: register ram_rdata into rdata[winner] and pulse rvalid[winner] (visible next cycle). Go to IDLE.
- Arbitration:
  - Only one request high: that requester wins.
  - Both high: the requester not granted last wins.
  - The last-grant pointer updates on entry to ISSUE.
- Outside ISSUE, ram_en=0 and ram_wr=0. ram_addr and ram_wdata hold their last values.
- Requester rule: req must be low in the cycle after gnt unless a new command is presented. A req dropped before gnt is a protocol violation; a command already latched still completes.
- Read-after-write to the same address, on either requester, returns the new data. Commands are strictly serialised, so no bypass is needed.

## Timing
- Reset (rst_n=0 at an edge) sets:
  - state to IDLE and the last-grant pointer to 1, so requester 0 wins the first tie
  - gnt, rvalid, ram_en and ram_wr to 0
  - ram_addr, ram_wdata and rdata to 0
- Read: req sampled in cycle 0, gnt and ram_en in cycle 1, ram_rdata valid in cycle 2, rvalid/rdata in cycle 3. Next issue is cycle 4 at the earliest.
- Write: req in cycle 0, gnt and ram_en/ram_wr in cycle 1, RAM updated at the end of cycle 1. The next request is sampled in cycle 2 and issued in cycle 3.
- Peak throughput: one write per 2 cycles, one read per 3 cycles.
- Reset asserted during ISSUE or RDWAIT aborts the command: no rvalid follows, and the RAM write happens only if the ISSUE edge had already passed.
- Address AW'hFF and AW'h00 need no special handling; there is no wrap logic.

## Structure
- Package ram_arb_pkg holds:
  - the state enum (IDLE, ISSUE, RDWAIT)
  - default AW/DW localparams
  - the requester-id type (1 bit)
- Sub-module rr_arb2: combinational two-way round-robin pick from req[1:0] plus the last-grant bit, returning winner id and any_req. The pointer register lives in ram_arbiter.
- The command register, FSM and per-requester rdata registers live in the top.

## Test plan
- Reset, then idle for 5 cycles: all outputs 0, and ram_en never goes high.
- req0 write addr 8'h10 data 8'hA5, then req0 read 8'h10: gnt0 in cycle 1; rvalid0 three cycles after the read req with rdata0=8'hA5.
- req0 and req1 both held, all reads of different addresses: grants alternate 0,1,0,1, starting with 0 after reset. Each rvalid goes only to its owner with the correct data.
- req1 writes 8'hFF to 8'h00 while req0 reads 8'h00 in the same cycle, with the last grant being 0: the write is issued first, and req0 reads back 8'hFF.
- rst_n pulled low during RDWAIT: rvalid never asserts, state returns to IDLE, and the next request is served normally.
- Back-to-back writes from req1 only, 20 commands: one gnt1 every 2 cycles, with ram_en pulses exactly matching the gnt1 pulses.
